gamecube_cmd_serializer: RTL

- Upstream feeder for the downstream Gamecube bit transmitter.
- Accepts a command of 1..MAX_BYTES bytes and presents it one bit at a time on TX_OUT / n_SEND_OUT.
- Bytes go first-byte-first, each byte MSB first, followed by one stop bit '1'.
- Paces itself off the transmitter's BUSY and reports completion to the controller FSM, e.g. for the 3-byte poll command 0x400300.

---
 rtl/gamecube_pkg.sv | 21 ++
 rtl/gc_edge_detect.sv | 25 ++
 rtl/gamecube_cmd_serializer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/gamecube_pkg.sv
// Shared definitions for the Gamecube command path: serializer state
// encoding and protocol constants.
package gamecube_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STOP  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Every command ends with a single '1' stop bit
    localparam logic GC_STOP_BIT = 1'b1;

    // Standard 3-byte controller poll command
    localparam logic [23:0] GC_POLL_CMD = 24'h400300;

    // Transmitter cycles per bit symbol
    localparam int GC_BITS_PER_SYMBOL = 4;

endpackage

// File: rtl/gc_edge_detect.sv
// Registers a level signal and reports its rising and falling transitions
// relative to the previous sample. Shared with the receiver path.
module gc_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_q;

    // Hold the previous sample so a transition can be seen on the next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;
    assign fall = ~sig & sig_q;

endmodule

// File: rtl/gamecube_cmd_serializer.sv
// Feeds a 1..MAX_BYTES command to the Gamecube bit transmitter one bit at a
// time (first byte first, MSB first, then a '1' stop bit). Each BUSY_IN rise
// means the transmitter took the current bit. DONE pulses once the
// transmitter drops BUSY after the stop bit.
// Optional build macro GC_SER_TIMEOUT_EN adds a watchdog that aborts with an
// ERR pulse when the transmitter stalls for TIMEOUT_CYCLES cycles.
module gamecube_cmd_serializer
    import gamecube_pkg::*;
#(
    parameter int MAX_BYTES      = 3,
    parameter int LEN_W          = $clog2(MAX_BYTES + 1),
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic [8*MAX_BYTES-1:0] DATA,
    input  logic [LEN_W-1:0]       LEN,
    input  logic                   BUSY_IN,
    output logic                   n_SEND_OUT,
    output logic                   TX_OUT,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   ERR
);

    localparam int DATA_BITS = 8 * MAX_BYTES;
    localparam int CNT_W     = $clog2(DATA_BITS + 1);

    state_t               state;
    logic [DATA_BITS-1:0] shreg;
    logic [CNT_W-1:0]     bits_left;
    logic                 rise;
    logic                 fall;
    logic                 len_ok;

    gc_edge_detect u_busy_edge (
        .clk  (CLK),
        .rst  (RST),
        .sig  (BUSY_IN),
        .rise (rise),
        .fall (fall)
    );

    // Commands of zero length or longer than the buffer are dropped
    assign len_ok = (LEN != '0) && (LEN <= LEN_W'(MAX_BYTES));

`ifdef GC_SER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_clear;
    logic            wd_hit;

    // Watchdog restarts on every sign of transmitter progress and idles in IDLE
    always_comb begin
        wd_clear = 1'b1;
        case (state)
            SEND, STOP: wd_clear = rise;
            DRAIN:      wd_clear = fall;
            default:    wd_clear = 1'b1;
        endcase
        wd_hit = !wd_clear && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    end
`else
    assign ERR = 1'b0;
`endif

    // Command sequencer: load, shift out on each accepted bit, stop bit, drain
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            n_SEND_OUT <= 1'b1;
            TX_OUT     <= 1'b1;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            bits_left  <= '0;
`ifdef GC_SER_TIMEOUT_EN
            ERR        <= 1'b0;
            wd_cnt     <= '0;
`endif
        end else begin
            DONE <= 1'b0;
`ifdef GC_SER_TIMEOUT_EN
            ERR <= 1'b0;
            if (wd_clear) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
`endif
            case (state)
                IDLE: begin
                    if (START && len_ok) begin
                        shreg      <= DATA;
                        bits_left  <= CNT_W'(LEN) << 3;
                        BUSY       <= 1'b1;
                        n_SEND_OUT <= 1'b0;
                        TX_OUT     <= DATA[DATA_BITS-1];
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (rise) begin
                        if (bits_left == CNT_W'(1)) begin
                            TX_OUT <= GC_STOP_BIT;
                            state  <= STOP;
                        end else begin
                            shreg  <= shreg << 1;
                            TX_OUT <= shreg[DATA_BITS-2];
                        end
                        bits_left <= bits_left - 1'b1;
                    end
                end
                STOP: begin
                    if (rise) begin
                        n_SEND_OUT <= 1'b1;
                        TX_OUT     <= GC_STOP_BIT;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fall) begin
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef GC_SER_TIMEOUT_EN
            if (wd_hit) begin
                state      <= IDLE;
                n_SEND_OUT <= 1'b1;
                TX_OUT     <= 1'b1;
                BUSY       <= 1'b0;
                ERR        <= 1'b1;
                wd_cnt     <= '0;
            end
`endif
        end
    end

endmodule
